clb_cfg_loader: RTL and testbench



---
 rtl/clb_cfg_pkg.sv | 29 ++
 rtl/clb_cfg_loader.sv | 115 +++++++++++
 tb/tb_clb_cfg_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/clb_cfg_pkg.sv
// ---------------------------------------------------------------------------
// clb_cfg_pkg
// Shared definitions for the CLB configuration loader:
//   - default scan-chain length (16 LUT bits + 1 config bit)
//   - bit-counter width derivation (2**CNT_W must exceed the chain length)
//   - loader FSM state encoding
//   - shift-order constant (LSB of the configuration word leaves first)
// ---------------------------------------------------------------------------
package clb_cfg_pkg;

    localparam int CHAIN_LEN_DEF = 17;

    // Smallest counter width whose range strictly exceeds n.
    function automatic int cnt_w_for(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_w_for(CHAIN_LEN_DEF);

    // Bit 0 of the configuration word is the first bit into the chain.
    localparam bit LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/clb_cfg_loader.sv
// ---------------------------------------------------------------------------
// clb_cfg_loader
// Accepts a parallel configuration word over a valid/ready handshake and
// serialises it LSB-first into the CLB scan chain, one bit per prog_clk.
// While shifting, the chain tail (prog_out) is captured so the previous
// chain contents can be read back and optionally checked against the last
// word that was fully loaded.
//
// Ports:
//   prog_clk    in   configuration clock (also clocks the CLB chain)
//   prog_rst_n  in   synchronous active-low reset
//   cfg_data    in   word to load, bit 0 shifted first
//   cfg_verify  in   sampled with cfg_data; compare readback at end of load
//   cfg_valid   in   host word valid
//   cfg_ready   out  loader idle and able to accept a word
//   prog_in     out  registered serial data to the CLB
//   prog_en     out  registered shift enable to the CLB
//   prog_out    in   serial data returned from the CLB chain tail
//   rb_data     out  bits captured from prog_out during the last load
//   done        out  one-cycle pulse marking load completion
//   verify_err  out  sticky readback mismatch flag (cleared by reset only)
// ---------------------------------------------------------------------------
module clb_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 prog_clk,
    input  logic                 prog_rst_n,
    input  logic [CHAIN_LEN-1:0] cfg_data,
    input  logic                 cfg_verify,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 prog_in,
    output logic                 prog_en,
    input  logic                 prog_out,
    output logic [CHAIN_LEN-1:0] rb_data,
    output logic                 done,
    output logic                 verify_err
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CHAIN_LEN-1:0] sreg;
    logic [CHAIN_LEN-1:0] shadow;
    logic                 vfy_q;
    logic                 shadow_valid;

    assign cfg_ready = prog_rst_n && (state == ST_IDLE);

    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            prog_in      <= 1'b0;
            prog_en      <= 1'b0;
            done         <= 1'b0;
            rb_data      <= '0;
            verify_err   <= 1'b0;
            shadow_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        sreg    <= cfg_data;
                        vfy_q   <= cfg_verify;
                        cnt     <= '0;
                        // First bit goes out together with the enable so the
                        // CLB shifts on the very next edge.
                        prog_en <= 1'b1;
                        prog_in <= cfg_data[0];
                        state   <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // Rotate instead of plain shift: after CHAIN_LEN edges the
                    // register holds the original word again, which becomes
                    // the new shadow without a separate copy register.
                    sreg         <= {sreg[0], sreg[CHAIN_LEN-1:1]};
                    // The CLB shifts on this same edge, so this is the tail
                    // bit from before the shift.
                    rb_data[cnt] <= prog_out;
                    cnt          <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        prog_en <= 1'b0;
                        prog_in <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        prog_in <= sreg[1];
                    end
                end

                ST_DONE: begin
                    if (vfy_q && shadow_valid && (rb_data != shadow)) begin
                        verify_err <= 1'b1;
                    end
                    shadow       <= sreg;
                    shadow_valid <= 1'b1;
                    state        <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clb_cfg_loader.sv
module tb_clb_cfg_loader;

    localparam int N = 17;

    logic         prog_clk   = 1'b0;
    logic         prog_rst_n = 1'b0;
    logic [N-1:0] cfg_data   = '0;
    logic         cfg_verify = 1'b0;
    logic         cfg_valid  = 1'b0;
    logic         prog_out;
    logic         cfg_ready;
    logic         prog_in;
    logic         prog_en;
    logic [N-1:0] rb_data;
    logic         done;
    logic         verify_err;

    always #5 prog_clk = ~prog_clk;

    clb_cfg_loader #(.CHAIN_LEN(N), .CNT_W(5)) dut (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .cfg_data   (cfg_data),
        .cfg_verify (cfg_verify),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .prog_in    (prog_in),
        .prog_en    (prog_en),
        .prog_out   (prog_out),
        .rb_data    (rb_data),
        .done       (done),
        .verify_err (verify_err)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- CLB scan-chain stand-in ----------------
    // mode 0: FIFO chain of N bits, mode 1: tail forced 0, mode 2: random tail
    logic [N-1:0] chain = '0;
    int           mode  = 0;
    logic         rnd   = 1'b0;

    always @(posedge prog_clk) if (prog_en === 1'b1) chain <= {chain[N-2:0], prog_in};
    always @(negedge prog_clk) rnd <= 1'($urandom_range(0, 1));
    always_comb begin
        prog_out = 1'b0;
        if (mode == 0)      prog_out = chain[N-1];
        else if (mode == 2) prog_out = rnd;
    end

    // ---------------- transaction-level reference model ----------------
    // m_ph: 0 = idle, 1..N = bit m_ph-1 on the wire, N+1 = completion cycle
    int           m_ph = 0;
    int           cyc = 0;
    int           n_acc = 0;
    logic [N-1:0] m_word = '0, m_shadow = '0, m_rb = '0;
    bit           m_vfy = 0, m_sv = 0, m_err = 0;
    int           acc_cyc[$];

    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (!prog_rst_n) begin
            m_ph <= 0; m_sv <= 0; m_err <= 0; m_rb <= '0;
        end else if (m_ph == 0) begin
            if (cfg_valid) begin
                m_ph <= 1; m_word <= cfg_data; m_vfy <= cfg_verify;
                n_acc <= n_acc + 1;
                acc_cyc.push_back(cyc);
            end
        end else if (m_ph <= N) begin
            m_rb[m_ph-1] <= prog_out;
            m_ph <= m_ph + 1;
        end else begin
            if (m_vfy && m_sv && (m_rb != m_shadow)) m_err <= 1;
            m_shadow <= m_word; m_sv <= 1; m_ph <= 0;
        end
    end

    always @(negedge prog_clk) begin
        bit   en_e;
        logic in_e;
        if (chk_en) begin
            en_e = (m_ph >= 1) && (m_ph <= N);
            in_e = 1'b0;
            if (en_e) in_e = m_word[m_ph-1];
            chk("cfg_ready", cfg_ready, prog_rst_n && (m_ph == 0));
            chk("prog_en", prog_en, en_e);
            chk("prog_in", prog_in, in_e);
            chk("done", done, m_ph == N + 1);
            chk("rb_data", rb_data, m_rb);
            chk("verify_err", verify_err, m_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge prog_clk); #2;
    endtask

    task automatic wait_acc();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (m_ph == 1) begin ok = 1; break; end
        end
        chk("accept_timeout", ok, 1);
    endtask

    task automatic send(input logic [N-1:0] w, input bit v,
                        output logic [5:0] pin, output int en_c, output int dn_c);
        cfg_data = w; cfg_verify = v; cfg_valid = 1'b1;
        wait_acc();
        cfg_valid = 1'b0;
        cfg_data  = N'($urandom);
        pin = '0; en_c = 0; dn_c = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c <= 6) pin[c-1] = prog_in;
            if (prog_en === 1'b1) en_c++;
            if (done === 1'b1 && dn_c == 0) dn_c = c;
            if (c < 20) tick();
        end
    endtask

    initial begin
        logic [5:0]   pin;
        int           en_c, dn_c, a0;
        logic [N-1:0] w [4];

        prog_rst_n = 1'b0;
        repeat (3) @(posedge prog_clk);
        #2;
        chk_en = 1'b1;
        chk("rst_ready", cfg_ready, 0);
        chk("rst_prog_en", prog_en, 0);
        chk("rst_rb", rb_data, 0);
        chk("rst_err", verify_err, 0);
        chk("rst_done", done, 0);
        prog_rst_n = 1'b1;
        tick();
        chk("idle_ready", cfg_ready, 1);

        // first load and its serial timing
        send(17'h1DDDC, 0, pin, en_c, dn_c);
        chk("t1_prog_in_c1_6", pin, 6'b011100);
        chk("t1_en_cycles", en_c, 17);
        chk("t1_done_cycle", dn_c, 18);

        // readback of previous word with verify
        send(17'h00001, 1, pin, en_c, dn_c);
        chk("t2_rb", rb_data, 17'h1DDDC);
        chk("t2_err", verify_err, 0);

        // forced-zero tail during a verify load
        send(17'h1DDDC, 0, pin, en_c, dn_c);
        mode = 1;
        send(17'h0AAAA, 1, pin, en_c, dn_c);
        mode = 0;
        chk("t3_rb_zero", rb_data, 0);
        chk("t3_err", verify_err, 1);
        send(17'h12345, 0, pin, en_c, dn_c);
        send(17'h0F0F0, 1, pin, en_c, dn_c);
        chk("t3_sticky", verify_err, 1);

        // cfg_valid held high across four words
        for (int i = 0; i < 4; i++) w[i] = N'($urandom);
        a0 = n_acc;
        acc_cyc.delete();
        cfg_verify = 1'b0;
        cfg_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cfg_data = w[k];
            wait_acc();
        end
        cfg_valid = 1'b0;
        repeat (20) tick();
        chk("b2b_count", n_acc - a0, 4);
        for (int i = 1; i < 4; i++) chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 19);
        chk("b2b_rb", rb_data, w[2]);

        // reset at shift cycle 8
        cfg_data = 17'h1DDDC; cfg_verify = 1'b0; cfg_valid = 1'b1;
        wait_acc();
        cfg_valid = 1'b0;
        repeat (7) tick();
        prog_rst_n = 1'b0;
        tick();
        chk("mid_prog_en", prog_en, 0);
        chk("mid_done", done, 0);
        prog_rst_n = 1'b1;
        #1;
        chk("mid_ready_after", cfg_ready, 1);
        repeat (3) tick();
        send(17'h00F0F, 1, pin, en_c, dn_c);
        chk("mid_vfy_err", verify_err, 0);

        // first load after reset with arbitrary tail bits
        prog_rst_n = 1'b0;
        tick();
        prog_rst_n = 1'b1;
        mode = 2;
        send(17'h15A5A, 1, pin, en_c, dn_c);
        chk("rand_first_err", verify_err, 0);
        mode = 0;

        // randomized traffic
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 9) == 0)      mode = 1;
            else if ($urandom_range(0, 3) == 0) mode = 2;
            else                                mode = 0;
            if ($urandom_range(0, 9) == 0) begin
                prog_rst_n = 1'b0;
                tick();
                prog_rst_n = 1'b1;
            end
            send(N'($urandom), 1'($urandom_range(0, 1)), pin, en_c, dn_c);
            repeat ($urandom_range(0, 3)) tick();
        end
        mode = 0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
